rom_loader: RTL
===============

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of BRAM bytes loaded and cleared.
REQ-002 SHALL have parameter INDEX, default 8'h00: ioctl_index value this loader accepts.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ioctl_download  input  1  HPS download active.
REQ-006 SHALL have port ioctl_index  input  8  download target selector.
REQ-007 SHALL have port ioctl_wr  input  1  one-cycle byte strobe.
REQ-008 SHALL have port ioctl_addr  input  25  byte address of ioctl_dout.
REQ-009 SHALL have port ioctl_dout  input  8  download byte.
REQ-010 SHALL have port ioctl_wait  output  1  stall request to HPS.
REQ-011 SHALL have port bram_download  output  1  BRAM owned by loader.
REQ-012 SHALL have port bram_wr  output  1  BRAM write strobe.
REQ-013 SHALL have port bram_init_address  output  16  BRAM write address.
REQ-014 SHALL have port bram_din  output  8  BRAM write data.
REQ-015 SHALL have port load_done  output  1  last download completed without abort.
REQ-016 SHALL have port overflow  output  1  a byte with address >= DEPTH was dropped.

Function
REQ-017 SHALL implement states IDLE, CLEAR, LOAD, DONE.
REQ-018 IDLE -> CLEAR SHALL occur in the cycle after ioctl_download rises while ioctl_index == INDEX; other indices SHALL be ignored entirely.
REQ-019 On CLEAR entry, load_done and overflow SHALL clear.
REQ-020 CLEAR SHALL write 8'h00 to addresses 0..DEPTH-1, one per cycle, ascending, bram_wr high each cycle; CLEAR lasts exactly DEPTH cycles, then enters LOAD.
REQ-021 ioctl_wait SHALL be high throughout CLEAR and low otherwise except per REQ-023.
REQ-022 In LOAD, ioctl_wr at cycle N with ioctl_addr < DEPTH SHALL produce bram_wr=1, bram_init_address=ioctl_addr[15:0], bram_din=ioctl_dout at cycle N+1 (one-cycle latency, registered).
REQ-023 A strobe arriving while the holding register is still full SHALL assert ioctl_wait the next cycle; no byte SHALL ever be lost or duplicated.
REQ-024 ioctl_wr with ioctl_addr >= DEPTH SHALL NOT write and SHALL set overflow sticky until next CLEAR entry.
REQ-025 ioctl_download falling in LOAD SHALL enter DONE after any pending byte is written; a strobe coincident with the fall SHALL still be written.
REQ-026 DONE SHALL last one cycle, set load_done (held until next CLEAR entry), then return to IDLE.
REQ-027 ioctl_download falling during CLEAR SHALL abort to IDLE; load_done SHALL stay 0.
REQ-028 bram_download SHALL be high in CLEAR, LOAD and DONE, low in IDLE.
REQ-029 bram_wr SHALL be 0 whenever bram_download is 0.

Reset
REQ-030 reset SHALL force state IDLE and all outputs to 0 (including checksum) on the next edge, from any state.
REQ-031 reset SHALL dominate every simultaneous input event; a byte pending at reset SHALL be discarded.

Configuration
REQ-032 With ROM_LOADER_CHECKSUM_EN defined, port checksum  output  8 SHALL exist: mod-256 sum of all bytes written in LOAD, zeroed on CLEAR entry, final value stable from DONE onward.
REQ-033 Without ROM_LOADER_CHECKSUM_EN, the checksum port and its adder SHALL be absent; all other behaviour identical.

Structure
REQ-034 State enumeration and the default DEPTH value SHALL live in shared package studio2_pkg.
REQ-035 Single flat module; no sub-module.

Verification
REQ-036 DEPTH=512: download rise, index 0 -> 512 consecutive bram_wr of 8'h00 at 0..511, ioctl_wait high exactly 512 cycles.
REQ-037 Bytes 8'hA5@0, 8'h3C@1, 8'hFF@511 -> each written one cycle after strobe; load_done=1 after fall; checksum=8'hE0 when macro defined.
REQ-038 Back-to-back strobes on consecutive cycles -> ioctl_wait asserts; all bytes written in order, none lost.
REQ-039 Byte at address 512 -> no write, overflow=1; load_done still 1 at end.
REQ-040 Download with ioctl_index=1 -> bram_download stays 0, no writes; reset asserted at clear address 100 -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/studio2_pkg.sv
// Shared definitions for the studio2 ROM loader: loader FSM states and default BRAM depth.
package studio2_pkg;

  localparam int DEFAULT_DEPTH = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/rom_loader.sv
// HPS ioctl download to BRAM loader: zero-fills DEPTH bytes, then streams downloaded bytes in.
// Define ROM_LOADER_CHECKSUM_EN to add the 8-bit running checksum output.
module rom_loader
  import studio2_pkg::*;
#(
  parameter int         DEPTH = DEFAULT_DEPTH,
  parameter logic [7:0] INDEX = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        bram_download,
  output logic        bram_wr,
  output logic [15:0] bram_init_address,
  output logic [7:0]  bram_din,
  output logic        load_done,
  output logic        overflow
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  checksum
`endif
);

  localparam logic [15:0] LastAddr = 16'(DEPTH - 1);

  loader_state_e state_q, state_d;
  logic        dlPrev_q;
  logic [15:0] clearCnt_q, clearCnt_d;
  logic        holdValid_q, holdValid_d;
  logic [15:0] holdAddr_q, holdAddr_d;
  logic [7:0]  holdData_q, holdData_d;
  logic        skidValid_q, skidValid_d;
  logic [15:0] skidAddr_q, skidAddr_d;
  logic [7:0]  skidData_q, skidData_d;
  logic        loadDone_q, loadDone_d;
  logic        overflow_q, overflow_d;
  logic        dlRise, inRange, accept, clearEntry;

  assign dlRise     = ioctl_download & ~dlPrev_q;
  assign inRange    = ioctl_addr < 25'(DEPTH);
  assign accept     = (state_q == LOAD) & ioctl_wr & inRange;
  assign clearEntry = (state_q == IDLE) & (state_d == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // LOAD only finishes once the holding and skid registers have both drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dlRise && ioctl_index == INDEX) state_d = CLEAR;
      CLEAR:   if (!ioctl_download) state_d = IDLE;
               else if (clearCnt_q == LastAddr) state_d = LOAD;
      LOAD:    if (!ioctl_download && !holdValid_d && !skidValid_d) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ioctl_wait        = 1'b0;
    bram_download     = 1'b0;
    bram_wr           = 1'b0;
    bram_init_address = '0;
    bram_din          = '0;
    unique case (state_q)
      CLEAR: begin
        ioctl_wait        = 1'b1;
        bram_download     = 1'b1;
        bram_wr           = 1'b1;
        bram_init_address = clearCnt_q;
      end
      LOAD: begin
        ioctl_wait        = skidValid_q;
        bram_download     = 1'b1;
        bram_wr           = holdValid_q;
        bram_init_address = holdAddr_q;
        bram_din          = holdData_q;
      end
      DONE:    bram_download = 1'b1;
      default: ;
    endcase
  end

  // The holding register empties every cycle; a strobe that finds it full parks in the skid
  // register (raising ioctl_wait) and moves into the holding register on the next edge.
  always_comb begin
    holdValid_d = 1'b0;
    holdAddr_d  = holdAddr_q;
    holdData_d  = holdData_q;
    skidValid_d = 1'b0;
    skidAddr_d  = skidAddr_q;
    skidData_d  = skidData_q;
    if (skidValid_q) begin
      holdValid_d = 1'b1;
      holdAddr_d  = skidAddr_q;
      holdData_d  = skidData_q;
    end else if (accept && !holdValid_q) begin
      holdValid_d = 1'b1;
      holdAddr_d  = ioctl_addr[15:0];
      holdData_d  = ioctl_dout;
    end
    if (accept && (holdValid_q || skidValid_q)) begin
      skidValid_d = 1'b1;
      skidAddr_d  = ioctl_addr[15:0];
      skidData_d  = ioctl_dout;
    end
  end

  always_comb begin
    clearCnt_d = (state_q == CLEAR) ? clearCnt_q + 16'd1 : 16'd0;
    loadDone_d = loadDone_q;
    overflow_d = overflow_q;
    if (clearEntry) begin
      loadDone_d = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (state_q == LOAD && state_d == DONE) loadDone_d = 1'b1;
      if (state_q == LOAD && ioctl_wr && !inRange) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clearCnt_q  <= '0;
      holdValid_q <= 1'b0;
      holdAddr_q  <= '0;
      holdData_q  <= '0;
      skidValid_q <= 1'b0;
      skidAddr_q  <= '0;
      skidData_q  <= '0;
      loadDone_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clearCnt_q  <= clearCnt_d;
      holdValid_q <= holdValid_d;
      holdAddr_q  <= holdAddr_d;
      holdData_q  <= holdData_d;
      skidValid_q <= skidValid_d;
      skidAddr_q  <= skidAddr_d;
      skidData_q  <= skidData_d;
      loadDone_q  <= loadDone_d;
      overflow_q  <= overflow_d;
    end
  end

  // Tracks the download line even through reset so a download held across reset does not restart.
  always_ff @(posedge clk) begin
    dlPrev_q <= ioctl_download;
  end

  assign load_done = loadDone_q;
  assign overflow  = overflow_q;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk) begin
    if (reset || clearEntry)             checksum_q <= '0;
    else if (state_q == LOAD && holdValid_q) checksum_q <= checksum_q + holdData_q;
  end

  assign checksum = checksum_q;
`endif

endmodule
